// File: rtl/maxpool_engine_if.sv
// Word-addressed memory port between the max-pool engine (master) and its memory (slave).
interface maxpool_engine_if #(
  parameter int DW = 16,
  parameter int AW = 27
);
  logic                 req;
  logic                 we;
  logic [AW-1:0]        addr;
  logic signed [DW-1:0] wdata;
  logic                 gnt;
  logic                 rvalid;
  logic signed [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/maxpool_engine.sv
// 2x2 stride-2 max-pooling engine: reads an int16 CHW map, writes the pooled CHW map, pulses mp_done.
module maxpool_engine #(
  parameter int DW   = 16,
  parameter int AW   = 27,
  parameter int CW   = 11,
  parameter int DIMW = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mp_rst,
  input  logic [AW-1:0]    mp_ifaddr,
  input  logic [AW-1:0]    mp_ofaddr,
  input  logic [CW-1:0]    mp_C,
  input  logic [DIMW-1:0]  mp_H,
  input  logic [DIMW-1:0]  mp_W,
  output logic             mp_done,
  maxpool_engine_if.master mem
);
  localparam int HWW = 2 * DIMW;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_SKIP, S_FLUSH, S_DONE
  } state_t;

  state_t               state, nxt;
  logic                 pend;
  logic [1:0]           k;
  logic [CW-1:0]        c_q, c_idx;
  logic [DIMW-1:0]      w_q, ho_q, wo_q, oy, ox;
  logic [HWW-1:0]       hw_q;
  logic                 degen_q;
  logic [AW-1:0]        chan_ptr, row_ptr, px_ptr, out_ptr;
  logic signed [DW-1:0] acc, wdata_q;

  logic                 start_degen, rd_gnt, wr_gnt, rv, abort, flush_req;
  logic                 ox_last, oy_last, c_last, last_px;
  logic [AW-1:0]        rd_off, hw_ext, w2_ext;

  // Tie keeps the incumbent value.
  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (b > a) ? b : a;
  endfunction

  assign start_degen = (mp_C == '0) || (mp_H < DIMW'(2)) || (mp_W < DIMW'(2));
  assign rd_gnt      = (state == S_RD_REQ) && mem.gnt;
  assign wr_gnt      = (state == S_WR_REQ) && mem.gnt;
  assign rv          = pend && mem.rvalid;
  assign abort       = mp_rst && (state != S_IDLE);
  // A read still in flight (or granted right now) must drain before restarting.
  assign flush_req   = (pend && !mem.rvalid) || rd_gnt;
  assign ox_last     = (ox == wo_q - DIMW'(1));
  assign oy_last     = (oy == ho_q - DIMW'(1));
  assign c_last      = (c_idx == c_q - CW'(1));
  assign last_px     = ox_last && oy_last && c_last;
  assign hw_ext      = AW'(hw_q);
  assign w2_ext      = AW'({w_q, 1'b0});
  assign mem.wdata   = wdata_q;

  always_comb begin
    case (k)
      2'd0:    rd_off = '0;
      2'd1:    rd_off = AW'(1);
      2'd2:    rd_off = AW'(w_q);
      default: rd_off = AW'(w_q) + AW'(1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt      = state;
    mp_done  = 1'b0;
    mem.req  = 1'b0;
    mem.we   = 1'b0;
    mem.addr = '0;
    case (state)
      S_IDLE:    if (mp_rst) nxt = start_degen ? S_SKIP : S_RD_REQ;
      S_RD_REQ: begin
        mem.req  = 1'b1;
        mem.addr = px_ptr + rd_off;
        if (mem.gnt) nxt = S_RD_WAIT;
      end
      S_RD_WAIT: if (rv) nxt = (k == 2'd3) ? S_WR_REQ : S_RD_REQ;
      S_WR_REQ: begin
        mem.req  = 1'b1;
        mem.we   = 1'b1;
        mem.addr = out_ptr;
        if (mem.gnt) nxt = last_px ? S_DONE : S_RD_REQ;
      end
      // Empty jobs still answer with the same start-to-done spacing.
      S_SKIP:    nxt = S_DONE;
      S_FLUSH:   if (rv) nxt = degen_q ? S_SKIP : S_RD_REQ;
      S_DONE: begin
        mp_done = 1'b1;
        nxt     = S_IDLE;
      end
      default:   nxt = S_IDLE;
    endcase
    if (abort) nxt = flush_req ? S_FLUSH : (start_degen ? S_SKIP : S_RD_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      k        <= '0;
      c_q      <= '0;
      c_idx    <= '0;
      w_q      <= '0;
      ho_q     <= '0;
      wo_q     <= '0;
      oy       <= '0;
      ox       <= '0;
      hw_q     <= '0;
      degen_q  <= 1'b0;
      chan_ptr <= '0;
      row_ptr  <= '0;
      px_ptr   <= '0;
      out_ptr  <= '0;
      acc      <= '0;
      wdata_q  <= '0;
    end else begin
      if (rd_gnt)  pend <= 1'b1;
      else if (rv) pend <= 1'b0;

      if (mp_rst) begin
        c_q      <= mp_C;
        w_q      <= mp_W;
        ho_q     <= mp_H >> 1;
        wo_q     <= mp_W >> 1;
        hw_q     <= HWW'(mp_H) * HWW'(mp_W);
        degen_q  <= start_degen;
        chan_ptr <= mp_ifaddr;
        row_ptr  <= mp_ifaddr;
        px_ptr   <= mp_ifaddr;
        out_ptr  <= mp_ofaddr;
        c_idx    <= '0;
        oy       <= '0;
        ox       <= '0;
        k        <= '0;
      end else begin
        if (state == S_RD_WAIT && rv) begin
          acc <= (k == 2'd0) ? mem.rdata : smax(acc, mem.rdata);
          if (k == 2'd3) wdata_q <= smax(acc, mem.rdata);
          k <= k + 2'd1;
        end
        // Walk the output raster; pointers advance incrementally, no multiply per access.
        if (wr_gnt) begin
          out_ptr <= out_ptr + AW'(1);
          if (!ox_last) begin
            ox     <= ox + DIMW'(1);
            px_ptr <= px_ptr + AW'(2);
          end else if (!oy_last) begin
            ox      <= '0;
            oy      <= oy + DIMW'(1);
            row_ptr <= row_ptr + w2_ext;
            px_ptr  <= row_ptr + w2_ext;
          end else if (!c_last) begin
            ox       <= '0;
            oy       <= '0;
            c_idx    <= c_idx + CW'(1);
            chan_ptr <= chan_ptr + hw_ext;
            row_ptr  <= chan_ptr + hw_ext;
            px_ptr   <= chan_ptr + hw_ext;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_maxpool_engine.sv
// Directed bench for maxpool_engine with a behavioural memory responder.
module tb_maxpool_engine;
  localparam int DW = 16, AW = 27, CW = 11, DIMW = 13;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mp_rst = 1'b0;
  logic [AW-1:0]   mp_ifaddr = '0, mp_ofaddr = '0;
  logic [CW-1:0]   mp_C = '0;
  logic [DIMW-1:0] mp_H = '0, mp_W = '0;
  logic            mp_done;

  int checks = 0, failures = 0;

  maxpool_engine_if #(.DW(DW), .AW(AW)) mem_if ();

  maxpool_engine #(.DW(DW), .AW(AW), .CW(CW), .DIMW(DIMW)) dut (
    .clk(clk), .rst_n(rst_n), .mp_rst(mp_rst), .mp_ifaddr(mp_ifaddr), .mp_ofaddr(mp_ofaddr),
    .mp_C(mp_C), .mp_H(mp_H), .mp_W(mp_W), .mp_done(mp_done), .mem(mem_if)
  );

  always #5 clk = ~clk;

  // Memory responder: decides grants and read returns on the falling edge.
  logic [DW-1:0] mem_arr [0:4095];
  int            gnt_pct = 100, rv_min = 1, rv_max = 1;
  bit            rd_pending = 1'b0, prev_stall = 1'b0;
  int            rd_timer = 0, req_cycles = 0, stab_err = 0;
  logic [DW-1:0] rd_data_q;
  logic          prev_we;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  logic [AW-1:0] wr_addr_q[$], rd_addr_q[$];
  logic [DW-1:0] wr_data_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_pending = 1'b0; rd_timer = 0; prev_stall = 1'b0;
      mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = '0;
    end else begin
      if (rd_pending && rd_timer == 0) begin
        mem_if.rvalid = 1'b1; mem_if.rdata = rd_data_q; rd_pending = 1'b0;
      end else begin
        mem_if.rvalid = 1'b0;
        if (rd_pending) rd_timer--;
      end
      mem_if.gnt = 1'b0;
      if (mem_if.req === 1'b1) begin
        req_cycles++;
        if (prev_stall && (mem_if.we !== prev_we || mem_if.addr !== prev_addr ||
                           mem_if.wdata !== prev_wdata)) stab_err++;
        prev_we = mem_if.we; prev_addr = mem_if.addr; prev_wdata = mem_if.wdata;
        if (int'($urandom_range(99)) < gnt_pct) begin
          mem_if.gnt = 1'b1;
          if (mem_if.we) begin
            mem_arr[mem_if.addr[11:0]] = mem_if.wdata;
            wr_addr_q.push_back(mem_if.addr);
            wr_data_q.push_back(mem_if.wdata);
          end else begin
            rd_data_q  = mem_arr[mem_if.addr[11:0]];
            rd_pending = 1'b1;
            rd_timer   = int'($urandom_range(rv_max, rv_min)) - 1;
            rd_addr_q.push_back(mem_if.addr);
          end
        end
        prev_stall = !mem_if.gnt;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
  endtask

  // Called just after a falling edge; the next rising edge samples mp_rst.
  task automatic start_job(input logic [CW-1:0] c, input logic [DIMW-1:0] h, input logic [DIMW-1:0] w,
                           input logic [AW-1:0] ia, input logic [AW-1:0] oa);
    mp_C = c; mp_H = h; mp_W = w; mp_ifaddr = ia; mp_ofaddr = oa; mp_rst = 1'b1;
  endtask

  // lat = falling-edge index (1 = cycle after mp_rst) of first mp_done, -1 if none.
  task automatic run_to_done(input int budget, output int lat, output int ndone);
    lat = -1; ndone = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (n == 1) mp_rst = 1'b0;
      if (mp_done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = n;
      end
      if (lat >= 0 && n >= lat + 3) break;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (mp_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h exp=0", mp_done); end
    checks++; if (mem_if.req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", mem_if.req); end
    checks++; if (mem_if.we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0h exp=0", mem_if.we); end
    checks++; if (mem_if.addr !== '0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", mem_if.addr); end
    checks++; if (mem_if.wdata !== '0) begin failures++; $display("FAIL reset_wdata got=%0h exp=0", mem_if.wdata); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (mem_if.req !== 1'b0) begin failures++; $display("FAIL idle_req got=%0h exp=0", mem_if.req); end
  endtask

  task automatic test_basic();
    int lat, nd;
    logic [DW-1:0] exp_d [4] = '{16'd5, 16'd7, 16'd13, 16'd15};
    logic [AW-1:0] exp_r [4] = '{27'h100, 27'h101, 27'h104, 27'h105};
    gnt_pct = 100; rv_min = 1; rv_max = 1;
    for (int i = 0; i < 16; i++) mem_arr[12'h100 + i] = DW'(i);
    clear_logs();
    @(negedge clk);
    start_job(1, 4, 4, 27'h100, 27'h200);
    run_to_done(200, lat, nd);
    checks++; if (lat != 37) begin failures++; $display("FAIL basic_latency got=%0d exp=37", lat); end
    checks++; if (nd != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", nd); end
    checks++; if (wr_addr_q.size() != 4) begin failures++; $display("FAIL basic_wr_count got=%0d exp=4", wr_addr_q.size()); end
    checks++; if (rd_addr_q.size() != 16) begin failures++; $display("FAIL basic_rd_count got=%0d exp=16", rd_addr_q.size()); end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== 27'h200 + AW'(i)) begin failures++; $display("FAIL basic_wr_addr[%0d] got=%0h exp=%0h", i, wr_addr_q[i], 27'h200 + i); end
      checks++; if (wr_data_q[i] !== exp_d[i]) begin failures++; $display("FAIL basic_wr_data[%0d] got=%0h exp=%0h", i, wr_data_q[i], exp_d[i]); end
    end
    for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) begin
      checks++; if (rd_addr_q[i] !== exp_r[i]) begin failures++; $display("FAIL basic_rd_addr[%0d] got=%0h exp=%0h", i, rd_addr_q[i], exp_r[i]); end
    end
  endtask

  task automatic test_signed_tie();
    int lat, nd;
    // 2x4 map: window 0 = {-3,-1,-1,-8}, window 1 = all 0x8000
    mem_arr[12'h300] = 16'hFFFD; mem_arr[12'h301] = 16'hFFFF;
    mem_arr[12'h304] = 16'hFFFF; mem_arr[12'h305] = 16'hFFF8;
    mem_arr[12'h302] = 16'h8000; mem_arr[12'h303] = 16'h8000;
    mem_arr[12'h306] = 16'h8000; mem_arr[12'h307] = 16'h8000;
    clear_logs();
    @(negedge clk);
    start_job(1, 2, 4, 27'h300, 27'h380);
    run_to_done(200, lat, nd);
    checks++; if (wr_addr_q.size() != 2) begin failures++; $display("FAIL signed_wr_count got=%0d exp=2", wr_addr_q.size()); end
    if (wr_data_q.size() >= 2) begin
      checks++; if (wr_data_q[0] !== 16'hFFFF) begin failures++; $display("FAIL signed_neg_max got=%0h exp=ffff", wr_data_q[0]); end
      checks++; if (wr_data_q[1] !== 16'h8000) begin failures++; $display("FAIL signed_min_tie got=%0h exp=8000", wr_data_q[1]); end
      checks++; if (wr_addr_q[1] !== 27'h381) begin failures++; $display("FAIL signed_wr_addr got=%0h exp=381", wr_addr_q[1]); end
    end
  endtask

  task automatic test_odd_dims();
    int lat, nd, bad, off, r;
    logic [DW-1:0] exp_d [4] = '{16'd4, 16'd10, 16'd104, 16'd110};
    for (int ch = 0; ch < 2; ch++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 3; x++)
          mem_arr[12'h400 + ch*15 + y*3 + x] = (x == 2 || y == 4) ? 16'h7FFF : DW'(ch*100 + y*3 + x);
    clear_logs();
    @(negedge clk);
    start_job(2, 5, 3, 27'h400, 27'h480);
    run_to_done(400, lat, nd);
    checks++; if (nd != 1) begin failures++; $display("FAIL odd_done_count got=%0d exp=1", nd); end
    checks++; if (wr_addr_q.size() != 4) begin failures++; $display("FAIL odd_wr_count got=%0d exp=4", wr_addr_q.size()); end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_data_q[i] !== exp_d[i] || wr_addr_q[i] !== 27'h480 + AW'(i)) begin
        failures++; $display("FAIL odd_wr[%0d] got=%0h@%0h exp=%0h@%0h", i, wr_data_q[i], wr_addr_q[i], exp_d[i], 27'h480 + i);
      end
    end
    checks++; if (rd_addr_q.size() != 16) begin failures++; $display("FAIL odd_rd_count got=%0d exp=16", rd_addr_q.size()); end
    if (rd_addr_q.size() > 8) begin
      checks++; if (rd_addr_q[8] !== 27'h40F) begin failures++; $display("FAIL odd_ch1_first_rd got=%0h exp=40f", rd_addr_q[8]); end
    end
    bad = 0;
    foreach (rd_addr_q[i]) begin
      off = int'(rd_addr_q[i]) - 'h400;
      r = off % 15;
      if (r / 3 == 4 || r % 3 == 2 || off < 0 || off >= 30) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL odd_dropped_reads got=%0d exp=0", bad); end
  endtask

  task automatic test_backpressure();
    int lat, nd, s0;
    logic signed [DW-1:0] e, v;
    logic [DW-1:0] exp_q[$];
    gnt_pct = 30; rv_min = 1; rv_max = 5;
    for (int i = 0; i < 90; i++) mem_arr[12'h600 + i] = DW'($urandom);
    // C=3, H=6, W=5 -> 3x2 outputs per channel, column 4 dropped
    for (int c = 0; c < 3; c++)
      for (int oy = 0; oy < 3; oy++)
        for (int ox = 0; ox < 2; ox++) begin
          e = mem_arr[12'h600 + c*30 + (2*oy)*5 + 2*ox];
          for (int d = 1; d < 4; d++) begin
            v = mem_arr[12'h600 + c*30 + (2*oy + d/2)*5 + 2*ox + d%2];
            if (v > e) e = v;
          end
          exp_q.push_back(e);
        end
    clear_logs();
    s0 = stab_err;
    @(negedge clk);
    start_job(3, 6, 5, 27'h600, 27'h700);
    run_to_done(20000, lat, nd);
    checks++; if (nd != 1) begin failures++; $display("FAIL bp_done_count got=%0d exp=1", nd); end
    checks++; if (stab_err != s0) begin failures++; $display("FAIL bp_stall_stability got=%0d exp=0", stab_err - s0); end
    checks++; if (wr_addr_q.size() != 18) begin failures++; $display("FAIL bp_wr_count got=%0d exp=18", wr_addr_q.size()); end
    for (int i = 0; i < 18 && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_data_q[i] !== exp_q[i] || wr_addr_q[i] !== 27'h700 + AW'(i)) begin
        failures++; $display("FAIL bp_wr[%0d] got=%0h@%0h exp=%0h@%0h", i, wr_data_q[i], wr_addr_q[i], exp_q[i], 27'h700 + i);
      end
    end
    gnt_pct = 100; rv_min = 1; rv_max = 1;
  endtask

  task automatic test_degenerate();
    int lat, nd, r0;
    logic [CW-1:0]   cs [3] = '{11'd0, 11'd1, 11'd1};
    logic [DIMW-1:0] hs [3] = '{13'd4, 13'd1, 13'd4};
    logic [DIMW-1:0] ws [3] = '{13'd4, 13'd4, 13'd1};
    for (int t = 0; t < 3; t++) begin
      r0 = req_cycles;
      @(negedge clk);
      start_job(cs[t], hs[t], ws[t], 27'h100, 27'h200);
      run_to_done(20, lat, nd);
      checks++; if (lat != 2) begin failures++; $display("FAIL degen%0d_latency got=%0d exp=2", t, lat); end
      checks++; if (nd != 1) begin failures++; $display("FAIL degen%0d_done_count got=%0d exp=1", t, nd); end
      checks++; if (req_cycles != r0) begin failures++; $display("FAIL degen%0d_requests got=%0d exp=0", t, req_cycles - r0); end
    end
  endtask

  task automatic test_abort();
    int lat = -1, nd = 0, rq = 0;
    gnt_pct = 100; rv_min = 4; rv_max = 4;
    for (int i = 0; i < 16; i++) mem_arr[12'h100 + i] = DW'(i);
    mem_arr[12'h140] = -16'sd10; mem_arr[12'h141] = -16'sd20;
    mem_arr[12'h142] = -16'sd30; mem_arr[12'h143] = -16'sd40;
    clear_logs();
    @(negedge clk);
    start_job(1, 4, 4, 27'h100, 27'h900);
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1 || n == 3) mp_rst = 1'b0;
      if (n == 2) begin
        rq = req_cycles;
        start_job(1, 2, 2, 27'h140, 27'h980);
      end
      if (n == 5) begin
        checks++; if (req_cycles != rq) begin failures++; $display("FAIL abort_req_during_flush got=%0d exp=0", req_cycles - rq); end
      end
      if (mp_done === 1'b1) begin nd++; if (lat < 0) lat = n; end
      if (lat >= 0 && n >= lat + 3) break;
    end
    checks++; if (nd != 1) begin failures++; $display("FAIL abort_done_count got=%0d exp=1", nd); end
    checks++; if (lat != 27) begin failures++; $display("FAIL abort_latency got=%0d exp=27", lat); end
    checks++; if (rd_addr_q.size() != 5) begin failures++; $display("FAIL abort_rd_count got=%0d exp=5", rd_addr_q.size()); end
    checks++; if (wr_addr_q.size() != 1) begin failures++; $display("FAIL abort_wr_count got=%0d exp=1", wr_addr_q.size()); end
    if (wr_addr_q.size() >= 1) begin
      checks++; if (wr_addr_q[0] !== 27'h980) begin failures++; $display("FAIL abort_wr_addr got=%0h exp=980", wr_addr_q[0]); end
      checks++; if (wr_data_q[0] !== 16'hFFF6) begin failures++; $display("FAIL abort_wr_data got=%0h exp=fff6", wr_data_q[0]); end
    end
    rv_min = 1; rv_max = 1;
  endtask

  task automatic test_back_to_back();
    int n1 = -1, n2 = -1, nd = 0;
    clear_logs();
    @(negedge clk);
    start_job(1, 2, 2, 27'h140, 27'h990);
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1 || (n1 > 0 && n == n1 + 1)) mp_rst = 1'b0;
      if (mp_done === 1'b1) begin
        nd++;
        if (n1 < 0) begin
          n1 = n;
          start_job(1, 2, 2, 27'h140, 27'h9A0);
        end else if (n2 < 0) n2 = n;
      end
      if (n2 > 0 && n >= n2 + 3) break;
    end
    checks++; if (n1 != 10) begin failures++; $display("FAIL b2b_first_done got=%0d exp=10", n1); end
    checks++; if (n2 != 20) begin failures++; $display("FAIL b2b_second_done got=%0d exp=20", n2); end
    checks++; if (nd != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", nd); end
    checks++; if (wr_addr_q.size() != 2) begin failures++; $display("FAIL b2b_wr_count got=%0d exp=2", wr_addr_q.size()); end
    if (wr_addr_q.size() >= 2) begin
      checks++; if (wr_addr_q[1] !== 27'h9A0 || wr_data_q[1] !== 16'hFFF6) begin
        failures++; $display("FAIL b2b_second_wr got=%0h@%0h exp=fff6@9a0", wr_data_q[1], wr_addr_q[1]);
      end
    end
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    @(negedge clk);
    start_job(1, 4, 4, 27'h100, 27'h200);
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) mp_rst = 1'b0;
      if (mem_if.req === 1'b1 && mem_if.we === 1'b1) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL async_no_write_seen got=0 exp=1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_if.req !== 1'b0) begin failures++; $display("FAIL async_req got=%0h exp=0", mem_if.req); end
    checks++; if (mem_if.we !== 1'b0) begin failures++; $display("FAIL async_we got=%0h exp=0", mem_if.we); end
    checks++; if (mem_if.addr !== '0) begin failures++; $display("FAIL async_addr got=%0h exp=0", mem_if.addr); end
    checks++; if (mem_if.wdata !== '0) begin failures++; $display("FAIL async_wdata got=%0h exp=0", mem_if.wdata); end
    checks++; if (mp_done !== 1'b0) begin failures++; $display("FAIL async_done got=%0h exp=0", mp_done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_signed_tie();
    test_odd_dims();
    test_backpressure();
    test_degenerate();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
